// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and constants for the pipeline control block.
//   Holds the memory FSM state enum, the scoreboard entry layout,
//   the architectural zero register and the default RAM access latency.
package pipe_ctrl_pkg;

    // Default number of RAM access cycles (legal range 1..7).
    localparam int RAM_LAT_DEF = 2;

    // Scoreboard register tags are stored at this fixed width so the
    // entry struct does not depend on the block's AW parameter.
    // AW must not exceed RD_W; narrower tags are zero-extended.
    localparam int RD_W = 16;

    localparam logic [RD_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            mem_rd;
        logic            mem_wr;
        logic [RD_W-1:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_NOP = '0;

    function automatic logic is_mem_op(sb_entry_t e);
        return e.valid && (e.mem_rd || e.mem_wr);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Decode-side handshake bundle of the pipeline controller.
//   master : pipeline datapath (drives decode info and flush,
//            receives buffer/stall/RAM controls and the stall counter)
//   slave  : pipe_ctrl
interface pipe_ctrl_if #(
    parameter int AW = 5
);
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_wE_BR;
    logic          id_W_ram;
    logic          id_R_ram;
    logic          flush;

    logic          buf_en;
    logic          buf_bubble;
    logic          id_stall;
    logic          ram_cs;
    logic          ram_we;
    logic [15:0]   stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_wE_BR, id_W_ram, id_R_ram, flush,
        input  buf_en, buf_bubble, id_stall, ram_cs, ram_we, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_wE_BR, id_W_ram, id_R_ram, flush,
        output buf_en, buf_bubble, id_stall, ram_cs, ram_we, stall_cnt
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Two-entry (EX, MEM) shift register of in-flight instruction control
//   info plus the read-after-write match against the decode operands.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     adv_i           shift: EX <- ins_i, MEM <- EX
//     clr_i           invalidate both entries (wins over adv_i)
//     ins_i           entry to load into EX (already NOP-ed by caller)
//     id_valid_i      decode slot holds an instruction
//     rs1_i, rs2_i    decode source registers (zero-extended)
//     ex_o            current EX entry
//     hazard_o        a decode source matches a pending register write
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adv_i,
    input  logic            clr_i,
    input  sb_entry_t       ins_i,
    input  logic            id_valid_i,
    input  logic [RD_W-1:0] rs1_i,
    input  logic [RD_W-1:0] rs2_i,
    output sb_entry_t       ex_o,
    output logic            hazard_o
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;

    // Register 0 is hard-wired, so a write to it never blocks a reader.
    function automatic logic hits(sb_entry_t e, logic [RD_W-1:0] r);
        return e.valid && e.we && (e.rd != REG_ZERO) && (e.rd == r);
    endfunction

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (clr_i) begin
            ex_d  = SB_NOP;
            mem_d = SB_NOP;
        end else if (adv_i) begin
            ex_d  = ins_i;
            mem_d = ex_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SB_NOP;
            mem_q <= SB_NOP;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign ex_o     = ex_q;
    assign hazard_o = id_valid_i &&
                      (hits(ex_q, rs1_i)  || hits(ex_q, rs2_i) ||
                       hits(mem_q, rs1_i) || hits(mem_q, rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline hazard and memory-freeze controller.
//   Priority: flush > memory freeze > data hazard (bubble) > advance.
//   A memory op in EX freezes the decode/execute buffers for RAM_LAT+1
//   cycles while the RAM is selected.
//   Ports:
//     clk    clock (rising edge)
//     rst_n  asynchronous active-low reset; forces all outputs low
//     bus    pipe_ctrl_if slave: decode info + flush in,
//            buf_en/buf_bubble/id_stall/ram_cs/ram_we/stall_cnt out
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW      = 5,
    parameter int RAM_LAT = RAM_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    pipe_ctrl_if.slave bus
);

    localparam logic [2:0] CNT_INIT = 3'(RAM_LAT - 1);

    mem_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    sb_entry_t   ex;
    sb_entry_t   ins;
    logic        hazard;

    logic        buf_en, buf_bubble, id_stall, ram_cs, ram_we;

    // Bubbles and invalid decode slots enter EX as NOPs.
    always_comb begin
        ins        = SB_NOP;
        ins.valid  = 1'b1;
        ins.we     = bus.id_wE_BR;
        ins.mem_rd = bus.id_R_ram;
        ins.mem_wr = bus.id_W_ram;
        ins.rd     = RD_W'(bus.id_rd);
        if (buf_bubble || !bus.id_valid) begin
            ins = SB_NOP;
        end
    end

    pipe_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (buf_en),
        .clr_i      (bus.flush),
        .ins_i      (ins),
        .id_valid_i (bus.id_valid),
        .rs1_i      (RD_W'(bus.id_rs1)),
        .rs2_i      (RD_W'(bus.id_rs2)),
        .ex_o       (ex),
        .hazard_o   (hazard)
    );

    // Memory FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem_op(ex)) begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pipeline control outputs. Gating on rst_n makes ram_cs drop the
    // moment reset asserts instead of waiting for the next edge.
    always_comb begin
        buf_en     = 1'b1;
        buf_bubble = 1'b0;
        id_stall   = 1'b0;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        if (!rst_n) begin
            buf_en = 1'b0;
        end else if (bus.flush) begin
            buf_bubble = 1'b1;
        end else if (state_q == ST_ACCESS) begin
            // Release the buffers on the last access cycle; a pending
            // hazard is seen again once the freeze is over.
            buf_en   = (cnt_q == 3'd0);
            id_stall = 1'b1;
            ram_cs   = 1'b1;
            ram_we   = ex.mem_wr;
        end else if (is_mem_op(ex)) begin
            buf_en   = 1'b0;
            id_stall = 1'b1;
            ram_cs   = 1'b1;
            ram_we   = ex.mem_wr;
        end else if (hazard) begin
            buf_bubble = 1'b1;
            id_stall   = 1'b1;
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.buf_en     = buf_en;
    assign bus.buf_bubble = buf_bubble;
    assign bus.id_stall   = id_stall;
    assign bus.ram_cs     = ram_cs;
    assign bus.ram_we     = ram_we;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl (AW=5, RAM_LAT=2). Output vector order
//   in checks: {buf_en, buf_bubble, id_stall, ram_cs, ram_we}.
module tb_pipe_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    pipe_ctrl_if #(.AW(5)) bus ();

    pipe_ctrl #(.AW(5), .RAM_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] ADV  = 5'b10000;
    localparam logic [4:0] HAZ  = 5'b11100;
    localparam logic [4:0] FRZL = 5'b00110;
    localparam logic [4:0] RELL = 5'b10110;
    localparam logic [4:0] FRZS = 5'b00111;
    localparam logic [4:0] RELS = 5'b10111;
    localparam logic [4:0] FLSH = 5'b11000;
    localparam logic [4:0] ZERO = 5'b00000;

    function automatic logic [4:0] outs();
        return {bus.buf_en, bus.buf_bubble, bus.id_stall, bus.ram_cs, bus.ram_we};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic wr,
                         input logic rdm, input logic fl);
        bus.id_valid = v;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
        bus.id_wE_BR = we;
        bus.id_W_ram = wr;
        bus.id_R_ram = rdm;
        bus.flush    = fl;
    endtask

    // Check outputs mid-cycle, then step past the next rising edge.
    task automatic cyc(input string tag, input logic [4:0] exp, input int exp_cnt);
        @(negedge clk);
        chk(tag, 32'(outs()), 32'(exp));
        if (exp_cnt >= 0) chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(exp_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Reset holds every output low whatever the inputs do
        rst_n = 1'b0;
        drive(1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'(ZERO));
        chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Independent instructions stream through
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'd1, 5'd2, 5'(10 + i), 1, 0, 0, 0);
            cyc("noDep", ADV, (i == 9) ? 0 : -1);
        end

        // rd=3 producer, then consumer of r3: bubble for EX, bubble for MEM
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
        cyc("prod3", ADV, -1);
        drive(1, 5'd3, 5'd0, 5'd5, 1, 0, 0, 0);
        cyc("hazEX", HAZ, 0);
        cyc("hazMEM", HAZ, 1);
        cyc("hazDone", ADV, 2);

        // Writes to r0 never stall
        drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0);
        cyc("prodR0", ADV, -1);
        drive(1, 5'd7, 5'd0, 5'd8, 0, 0, 0, 0);
        cyc("useR0", ADV, 2);

        // Load: RAM selected 3 cycles, buffers released in the third
        drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 1, 0);
        cyc("ldIssue", ADV, -1);
        drive(1, 5'd1, 5'd2, 5'd11, 1, 0, 0, 0);
        cyc("ld1", FRZL, -1);
        cyc("ld2", FRZL, -1);
        cyc("ld3", RELL, -1);

        // Store: same window with the write strobe
        drive(1, 5'd1, 5'd2, 5'd12, 0, 1, 0, 0);
        cyc("stIssue", ADV, 5);
        drive(1, 5'd1, 5'd2, 5'd13, 0, 0, 0, 0);
        cyc("st1", FRZS, -1);
        cyc("st2", FRZS, -1);
        cyc("st3", RELS, -1);

        // Flush aborts an access in progress and empties the scoreboard
        drive(1, 5'd1, 5'd2, 5'd14, 1, 0, 1, 0);
        cyc("fl_ld", ADV, 8);
        drive(1, 5'd1, 5'd2, 5'd15, 0, 0, 0, 0);
        cyc("fl_frz", FRZL, -1);
        drive(1, 5'd1, 5'd2, 5'd15, 0, 0, 0, 0);
        bus.flush = 1'b1;
        cyc("flush", FLSH, -1);
        // r14 would hazard if the load were still tracked
        drive(1, 5'd14, 5'd0, 5'd16, 1, 0, 1, 0);
        cyc("postFl", ADV, 9);

        // Freeze beats hazard; the hazard shows up once the freeze ends
        drive(1, 5'd16, 5'd0, 5'd17, 0, 0, 0, 0);
        cyc("fh1", FRZL, -1);
        cyc("fh2", FRZL, -1);
        cyc("fh3", RELL, -1);
        cyc("fhHaz", HAZ, -1);
        drive(1, 5'd16, 5'd0, 5'd18, 1, 0, 1, 0);
        cyc("fhAdv", ADV, 13);

        // Asynchronous reset in the middle of an access
        drive(1, 5'd1, 5'd2, 5'd19, 0, 0, 0, 0);
        cyc("ar_frz", FRZL, -1);
        #1;
        chk("ar_cs_before", 32'(bus.ram_cs), 32'd1);
        chk("ar_cnt_before", 32'(bus.stall_cnt), 32'd14);
        rst_n = 1'b0;
        #1;
        chk("ar_outs", 32'(outs()), 32'(ZERO));
        chk("ar_cnt", 32'(bus.stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back loads keep decode stalled; counter saturates
        drive(1, 5'd1, 5'd2, 5'd20, 1, 0, 1, 0);
        cyc("sat_first", ADV, 0);
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
        chk("sat_stall", 32'(bus.id_stall), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter RAM_LAT, default 2, RAM access cycles, legal 1..7.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  decode stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  input  AW  decode source registers.
REQ-007 id_rd  input  AW  decode destination register.
REQ-008 id_wE_BR, id_W_ram, id_R_ram  input  1  decode control bits (register write, RAM write, RAM read).
REQ-009 flush  input  1  discard all in-flight instructions (branch taken).
REQ-010 buf_en  output  1  advance decode/execute buffers this cycle.
REQ-011 buf_bubble  output  1  load a NOP (all control bits 0) into the execute buffer instead of decode data.
REQ-012 id_stall  output  1  hold fetch/decode.
REQ-013 ram_cs, ram_we  output  1  RAM select, RAM write strobe.
REQ-014 stall_cnt  output  16  saturating count of cycles with id_stall=1.

Function
REQ-015 Scoreboard: two entries EX, MEM of {valid, wE, mem_rd, mem_wr, rd}; on buf_en, EX<-decode (or NOP if buf_bubble or !id_valid), MEM<-EX.
REQ-016 Hazard: id_valid and (id_rs1 or id_rs2) equals rd of a valid EX/MEM entry with wE=1 and rd!=0 -> buf_en=1, buf_bubble=1, id_stall=1.
REQ-017 Register 0 never causes a hazard.
REQ-018 Memory FSM states IDLE, ACCESS; counter cnt 3 bits.
REQ-019 IDLE, EX valid with mem_rd or mem_wr -> buf_en=0, id_stall=1, ram_cs=1, next ACCESS, cnt<=RAM_LAT-1.
REQ-020 ACCESS: ram_cs=1, ram_we=EX.mem_wr, buf_en=0, id_stall=1; cnt==0 -> buf_en=1 this cycle, next IDLE; else cnt decrements.
REQ-021 A memory op therefore holds EX for exactly RAM_LAT+1 cycles; RAM_LAT=1 gives 2.
REQ-022 Priority: flush > memory freeze > hazard > normal advance (buf_en=1, others 0).
REQ-023 Freeze and hazard simultaneous: freeze wins, buf_bubble=0, hazard re-evaluated after freeze.
REQ-024 flush: next edge clears both entries' valid, FSM->IDLE, cnt->0; in flush cycle buf_en=1, buf_bubble=1, id_stall=0, ram_cs=0, ram_we=0.
REQ-025 flush during ACCESS aborts the access; ram_cs low from the flush cycle onward.
REQ-026 stall_cnt increments by 1 each cycle id_stall=1, holds at 16'hFFFF.
REQ-027 ram_we=0 whenever ram_cs=0.

Reset
REQ-028 rst_n low: scoreboard entries invalid, FSM IDLE, cnt=0, stall_cnt=0, all outputs 0 regardless of inputs.
REQ-029 Reset asserted mid-ACCESS drops ram_cs immediately, asynchronously.
REQ-030 First rising edge after rst_n release behaves as normal advance with empty scoreboard.

Structure
REQ-031 Package pipe_ctrl_pkg holds the FSM state enum, scoreboard entry struct, REG_ZERO constant, default RAM_LAT.
REQ-032 One sub-module pipe_scoreboard: two-entry shift register plus match logic; FSM and stall counter stay in pipe_ctrl.

Verification
REQ-033 No dependencies, id_valid=1 for 10 cycles -> buf_en=1 every cycle, id_stall=0, stall_cnt=0.
REQ-034 EX holds wE=1, rd=3; decode rs1=3 -> one cycle buf_bubble=1, id_stall=1; rd=3 reaches MEM -> second bubble; then advance; stall_cnt=2.
REQ-035 rd=0 wE=1 in EX, decode rs2=0 -> no stall.
REQ-036 RAM_LAT=2, load in EX -> ram_cs=1, ram_we=0 for 3 cycles, buf_en=1 only in third; store -> ram_we=1 same window.
REQ-037 flush in second ACCESS cycle -> ram_cs=0 same cycle, scoreboard empty next cycle, FSM IDLE.
REQ-038 rst_n low during ACCESS -> ram_cs=0 before next clock edge, stall_cnt=0; force 70000 stall cycles -> stall_cnt=16'hFFFF.
